fetch_unit: RTL and testbench

//   Instruction-fetch stage of the pipelined MIPS CPU. Owns the PC register,

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 71 +++++++
 tb/tb_fetch_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// IF/ID bundle between fetch and its neighbours: stall/redirect in, pipeline register out.
// The fetch stage uses the master side; decode/hazard/execute logic uses the slave side.
interface fetch_unit_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        fetch_fault_o;
  logic [31:0] fetch_count_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i,
    output pc_o, pc_plus4_o, instr_o, valid_o, fetch_fault_o, fetch_count_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i,
    input  pc_o, pc_plus4_o, instr_o, valid_o, fetch_fault_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, combinational program ROM read and the
// IF/ID pipeline register, with stall hold and redirect squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 1024,
  parameter int          ROM_AW    = 10
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  logic [31:0] rom [ROM_WORDS];

  logic [31:0] r_pc;
  logic [31:0] r_pc_o;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic        r_valid;
  logic        r_fault;

  logic [31:0] w_pc_next;
  logic [31:0] w_redir_pc;
  logic [31:0] w_word;
  logic        w_in_range;

  assign w_pc_next  = r_pc + 32'd4;
  assign w_redir_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign w_in_range = (r_pc[31:ROM_AW+2] == '0);
  assign w_word     = rom[r_pc[ROM_AW+1:2]];

  // IF/ID stage boundary: reset > redirect > stall > advance
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_pc_o     <= '0;
      r_pc_plus4 <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_count    <= '0;
    end else if (bus.redirect_i) begin
      r_pc       <= w_redir_pc;
      r_pc_o     <= '0;
      r_pc_plus4 <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
    end else if (!bus.stall_i) begin
      r_pc       <= w_pc_next;
      r_pc_o     <= r_pc;
      r_pc_plus4 <= w_pc_next;
      if (w_in_range) begin
        r_instr <= w_word;
        r_valid <= 1'b1;
        r_count <= r_count + 32'd1;
      end else begin
        // PC keeps advancing past the ROM so a later redirect can recover
        r_instr <= '0;
        r_valid <= 1'b0;
        r_fault <= 1'b1;
      end
    end
  end

  assign bus.pc_o          = r_pc_o;
  assign bus.pc_plus4_o    = r_pc_plus4;
  assign bus.instr_o       = r_instr;
  assign bus.valid_o       = r_valid;
  assign bus.fetch_fault_o = r_fault;
  assign bus.fetch_count_o = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural fetch model.
module tb_fetch_unit;
  localparam int ROM_WORDS = 1024;

  logic clk = 1'b0;
  logic reset;
  fetch_unit_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(ROM_WORDS), .ROM_AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] romm [ROM_WORDS];

  // reference model state
  logic [31:0] m_pc, m_pco, m_p4, m_instr, m_cnt;
  logic        m_vld, m_flt;

  typedef struct {
    bit rn; bit st; bit rd; logic [31:0] rpc;
    logic [31:0] pc; logic [31:0] p4; logic [31:0] instr; bit vld; bit flt; logic [31:0] cnt;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_all(input string tag, input logic [31:0] pc, input logic [31:0] p4,
                            input logic [31:0] instr, input bit vld, input bit flt,
                            input logic [31:0] cnt);
    chk({tag, ".pc_o"}, bus_if.pc_o, pc);
    chk({tag, ".pc_plus4_o"}, bus_if.pc_plus4_o, p4);
    chk({tag, ".instr_o"}, bus_if.instr_o, instr);
    chk({tag, ".valid_o"}, {31'd0, bus_if.valid_o}, {31'd0, vld});
    chk({tag, ".fetch_fault_o"}, {31'd0, bus_if.fetch_fault_o}, {31'd0, flt});
    chk({tag, ".fetch_count_o"}, bus_if.fetch_count_o, cnt);
  endtask

  // behavioural model of one clock edge
  task automatic model_edge(input bit rn, input bit st, input bit rd, input logic [31:0] rpc);
    if (!rn) begin
      m_pc = 32'h0; m_pco = 0; m_p4 = 0; m_instr = 0; m_vld = 0; m_flt = 0; m_cnt = 0;
    end else if (rd) begin
      m_pc = rpc - (rpc % 4);
      m_pco = 0; m_p4 = 0; m_instr = 0; m_vld = 0;
    end else if (!st) begin
      m_pco = m_pc;
      m_p4 = m_pc + 32'd4;
      if (m_pc < ROM_WORDS * 4) begin
        m_instr = romm[m_pc / 4]; m_vld = 1; m_cnt = m_cnt + 1;
      end else begin
        m_instr = 0; m_vld = 0; m_flt = 1;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  // drive one cycle, step the model at the edge, leave time at the negedge
  task automatic step(input bit rn, input bit st, input bit rd, input logic [31:0] rpc);
    reset = rn;
    bus_if.stall_i = st;
    bus_if.redirect_i = rd;
    bus_if.redirect_pc_i = rpc;
    @(posedge clk);
    model_edge(rn, st, rd, rpc);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    bus_if.stall_i = 1'b0;
    bus_if.redirect_i = 1'b0;
    bus_if.redirect_pc_i = '0;

    for (int i = 0; i < ROM_WORDS; i++) romm[i] = 32'hA000_0000 + i;
    romm[0] = 32'h2008_0005; romm[1] = 32'h2009_0007;
    romm[2] = 32'h0109_5020; romm[3] = 32'hAC0A_0000;
    for (int i = 0; i < ROM_WORDS; i++) dut.rom[i] = romm[i];

    //           rn st rd rpc       pc         p4         instr          vld flt cnt
    tbl[0]  = '{0, 0, 0, 32'h0,  32'h0,  32'h0,  32'h0,          0, 0, 32'd0};
    tbl[1]  = '{1, 0, 0, 32'h0,  32'h0,  32'h4,  32'h2008_0005,  1, 0, 32'd1};
    tbl[2]  = '{1, 0, 0, 32'h0,  32'h4,  32'h8,  32'h2009_0007,  1, 0, 32'd2};
    tbl[3]  = '{1, 0, 0, 32'h0,  32'h8,  32'hC,  32'h0109_5020,  1, 0, 32'd3};
    tbl[4]  = '{1, 1, 0, 32'h0,  32'h8,  32'hC,  32'h0109_5020,  1, 0, 32'd3};
    tbl[5]  = '{1, 1, 0, 32'h0,  32'h8,  32'hC,  32'h0109_5020,  1, 0, 32'd3};
    tbl[6]  = '{1, 0, 0, 32'h0,  32'hC,  32'h10, 32'hAC0A_0000,  1, 0, 32'd4};
    tbl[7]  = '{1, 0, 0, 32'h0,  32'h10, 32'h14, 32'hA000_0004,  1, 0, 32'd5};
    tbl[8]  = '{1, 0, 1, 32'h12, 32'h0,  32'h0,  32'h0,          0, 0, 32'd5};
    tbl[9]  = '{1, 0, 0, 32'h0,  32'h10, 32'h14, 32'hA000_0004,  1, 0, 32'd6};
    tbl[10] = '{1, 1, 1, 32'h8,  32'h0,  32'h0,  32'h0,          0, 0, 32'd6};
    tbl[11] = '{1, 1, 0, 32'h0,  32'h0,  32'h0,  32'h0,          0, 0, 32'd6};
    tbl[12] = '{1, 0, 0, 32'h0,  32'h8,  32'hC,  32'h0109_5020,  1, 0, 32'd7};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rn, tbl[i].st, tbl[i].rd, tbl[i].rpc);
      expect_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].p4, tbl[i].instr,
                 tbl[i].vld, tbl[i].flt, tbl[i].cnt);
    end

    // out-of-ROM fetch: sticky fault survives a recovering redirect, cleared by reset
    step(1, 0, 1, 32'h0000_1000);
    expect_all("oor_redir", 0, 0, 0, 0, 0, 7);
    step(1, 0, 0, 0);
    expect_all("oor_fetch", 32'h1000, 32'h1004, 0, 0, 1, 7);
    step(1, 0, 1, 32'h0);
    expect_all("oor_back", 0, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0);
    expect_all("oor_recover", 0, 4, 32'h2008_0005, 1, 1, 8);
    step(0, 0, 0, 0);
    expect_all("oor_reset", 0, 0, 0, 0, 0, 0);

    // reset while stalled at pc 0x20
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    expect_all("run_to_20", 32'h1C, 32'h20, 32'hA000_0007, 1, 0, 8);
    step(0, 1, 0, 0);
    expect_all("rst_in_stall", 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_all("post_rst", 0, 4, 32'h2008_0005, 1, 0, 1);

    // randomized traffic against the model, including ROM-edge and PC-wrap targets
    for (int n = 0; n < 3000; n++) begin
      bit rn, st, rd;
      logic [31:0] rpc;
      rn = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 9))
        0: rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        1: rpc = 32'h0000_1000 - $urandom_range(0, 15);
        default: rpc = $urandom_range(0, 4095);
      endcase
      step(rn, st, rd, rpc);
      expect_all($sformatf("rnd%0d", n), m_pco, m_p4, m_instr, m_vld, m_flt, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
